salvo_launch_arbiter: RTL and testbench

// - Shares the weapons control unit launcher between NUM_REQ fire requesters (0 = pilot, 1 = autonomous targeting, 2 = ground link).
// - Grants one requester at a time, then sequences its salvo as spaced fire_command bursts to the WCU.
// - Counts WCU launch_missile acknowledgements; ends on salvo complete, empty magazine, ack timeout or request withdrawal.

---
 rtl/salvo_launch_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_salvo_launch_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salvo_launch_arbiter.sv
// Launcher arbiter: grants one fire requester at a time and sequences its salvo to the WCU.
// Define SALVO_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module salvo_launch_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int SALVO_W     = 3,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SALVO_W-1:0] req_salvo,
    input  logic                       target_locked,
    input  logic [3:0]                 remaining_missiles,
    input  logic                       launch_missile,
    output logic                       fire_command,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       done,
    output logic                       abort,
    output logic [SALVO_W-1:0]         fired_count,
    output logic [2:0]                 seq_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FIRE  = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    localparam int TMR_W = $clog2(ACK_TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2:0]         state, state_nxt;
    logic [SALVO_W-1:0] shots_left, shots_nxt;
    logic [SALVO_W-1:0] fired_nxt;
    logic [TMR_W-1:0]   ack_tmr, tmr_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [SALVO_W-1:0] win_salvo;
    logic               owner_req;
    logic               mag_empty;
    logic               lock_unused;

    // Lock loss surfaces as a missing launch ack, so lock itself is only observed.
    assign lock_unused = target_locked;
    assign seq_state   = state;
    assign owner_req   = |(req & grant);
    assign mag_empty   = (remaining_missiles == 4'd0);

`ifdef SALVO_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] rr_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = IDX_W'((32'(last_winner) + 1 + k) % NUM_REQ);
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= IDX_W'(NUM_REQ - 1);
        end else if (state == ST_IDLE && state_nxt == ST_FIRE) begin
            last_winner <= win_idx;
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        win_salvo = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_salvo = req_salvo[k*SALVO_W +: SALVO_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        shots_nxt = shots_left;
        fired_nxt = fired_count;
        tmr_nxt   = ack_tmr;
        gap_nxt   = gap_cnt;
        grant_nxt = grant;
        case (state)
            ST_IDLE: begin
                if (win_found && !mag_empty) begin
                    state_nxt = ST_FIRE;
                    shots_nxt = (win_salvo == '0) ? SALVO_W'(1) : win_salvo;
                    fired_nxt = '0;
                    tmr_nxt   = '0;
                    grant_nxt = NUM_REQ'(1) << win_idx;
                end
            end
            ST_FIRE: begin
                // A launch is counted even when an abort wins the transition this cycle.
                if (launch_missile) begin
                    fired_nxt = fired_count + 1'b1;
                    shots_nxt = shots_left - 1'b1;
                end
                if (!owner_req || (mag_empty && shots_left != '0)) begin
                    state_nxt = ST_ABORT;
                end else if (launch_missile) begin
                    if (shots_left == SALVO_W'(1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_GAP;
                        gap_nxt   = '0;
                    end
                end else if (ack_tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = ST_ABORT;
                end else begin
                    tmr_nxt = ack_tmr + 1'b1;
                end
            end
            ST_GAP: begin
                if (!owner_req || (mag_empty && shots_left != '0)) begin
                    state_nxt = ST_ABORT;
                end else if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
                    state_nxt = ST_FIRE;
                    tmr_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (state_nxt != ST_FIRE && state_nxt != ST_GAP) begin
            grant_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shots_left   <= '0;
            ack_tmr      <= '0;
            gap_cnt      <= '0;
            fire_command <= 1'b0;
            grant        <= '0;
            done         <= 1'b0;
            abort        <= 1'b0;
            fired_count  <= '0;
        end else begin
            state        <= state_nxt;
            shots_left   <= shots_nxt;
            ack_tmr      <= tmr_nxt;
            gap_cnt      <= gap_nxt;
            fire_command <= (state_nxt == ST_FIRE);
            grant        <= grant_nxt;
            done         <= (state_nxt == ST_DONE);
            abort        <= (state_nxt == ST_ABORT);
            fired_count  <= fired_nxt;
        end
    end

endmodule

// File: tb/tb_salvo_launch_arbiter.sv
// Scoreboard bench for salvo_launch_arbiter with a behavioural WCU that acks after ACK_DLY fire cycles.
module tb_salvo_launch_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int SALVO_W     = 3;
    localparam int GAP_CYCLES  = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int ACK_DLY     = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*SALVO_W-1:0] req_salvo;
    logic                       target_locked;
    logic [3:0]                 remaining_missiles;
    logic                       launch_missile;
    logic                       fire_command;
    logic [NUM_REQ-1:0]         grant;
    logic                       done;
    logic                       abort;
    logic [SALVO_W-1:0]         fired_count;
    logic [2:0]                 seq_state;

    typedef struct packed {
        logic               is_abort;
        logic [SALVO_W-1:0] fired;
    } end_t;

    end_t               exp_end[$];
    logic [NUM_REQ-1:0] exp_grant[$];
    int                 low_runs[$];

    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 fire_age = 0;
    int                 rise_cnt = 0;
    int                 last_rise = 0;
    int                 low_run = 0;
    logic               mag_track = 1'b0;
    logic               prev_fire = 1'b0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    salvo_launch_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SALVO_W    (SALVO_W),
        .GAP_CYCLES (GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_salvo         (req_salvo),
        .target_locked     (target_locked),
        .remaining_missiles(remaining_missiles),
        .launch_missile    (launch_missile),
        .fire_command      (fire_command),
        .grant             (grant),
        .done              (done),
        .abort             (abort),
        .fired_count       (fired_count),
        .seq_state         (seq_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_end(input logic is_ab, input int fired);
        end_t e;
        e.is_abort = is_ab;
        e.fired    = SALVO_W'(fired);
        exp_end.push_back(e);
    endtask

    // One clock: sample outputs on the falling edge, score them, then drive the WCU model.
    task automatic tick();
        end_t e;
        @(negedge clk);
        cyc++;
        if (done || abort) begin
            if (exp_end.size() == 0) begin
                check_eq("unexpected_end", 1, 0);
            end else begin
                e = exp_end.pop_front();
                check_eq("end_kind", int'({done, abort}), e.is_abort ? 1 : 2);
                check_eq("end_fired", int'(fired_count), int'(e.fired));
                check_eq("end_grant", int'(grant), 0);
                check_eq("end_fire_cmd", int'(fire_command), 0);
            end
        end
        if (prev_grant == '0 && grant != '0) begin
            if (exp_grant.size() == 0) check_eq("unexpected_grant", int'(grant), 0);
            else check_eq("grant", int'(grant), int'(exp_grant.pop_front()));
        end
        prev_grant = grant;
        if (fire_command) begin
            if (!prev_fire) begin
                rise_cnt++;
                last_rise = cyc;
                if (rise_cnt > 1) low_runs.push_back(low_run);
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_fire = fire_command;
        if (launch_missile && mag_track && remaining_missiles != 4'd0)
            remaining_missiles = remaining_missiles - 4'd1;
        launch_missile = 1'b0;
        if (fire_command) begin
            fire_age++;
            if (fire_age == ACK_DLY && target_locked) launch_missile = 1'b1;
        end else begin
            fire_age = 0;
        end
    endtask

    task automatic wait_end(input string tag, input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(done || abort) && n < limit);
        if (!(done || abort)) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n;
        rst                = 1'b1;
        req                = '0;
        req_salvo          = '0;
        target_locked      = 1'b1;
        remaining_missiles = 4'd6;
        launch_missile     = 1'b0;
        tick();
        tick();
        check_eq("rst_state", int'(seq_state), 0);
        check_eq("rst_fire", int'(fire_command), 0);
        check_eq("rst_grant", int'(grant), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_abort", int'(abort), 0);
        check_eq("rst_fired", int'(fired_count), 0);
        rst = 1'b0;
        tick();

        // Single salvo of 3 with spacing measurement.
        req_salvo = 9'd3;
        req       = 3'b001;
        exp_grant.push_back(3'b001);
        push_end(1'b0, 3);
        rise_cnt = 0;
        low_runs.delete();
        tick();
        check_eq("req_to_fire", int'(fire_command), 1);
        check_eq("fire_state", int'(seq_state), 1);
        wait_end("single", 200);
        req = '0;
        check_eq("bursts", rise_cnt, 3);
        check_eq("gap_count", low_runs.size(), 2);
        foreach (low_runs[i]) check_eq("gap_len", low_runs[i], GAP_CYCLES + 1);
        tick();
        check_eq("done_width", int'(done), 0);
        check_eq("fired_hold", int'(fired_count), 3);
        check_eq("idle_after_done", int'(seq_state), 0);

        // Size 0 counts as a single shot.
        req_salvo = 9'd0;
        req       = 3'b001;
        exp_grant.push_back(3'b001);
        push_end(1'b0, 1);
        wait_end("zero_size", 200);
        req = '0;
        tick();

        // Contention between requesters 1 and 2.
        req_salvo = {3'd1, 3'd1, 3'd0};
        req       = 3'b110;
        exp_grant.push_back(3'b010);
        push_end(1'b0, 1);
        wait_end("cont1", 200);
`ifndef SALVO_ARB_ROUND_ROBIN_EN
        req = 3'b100;
`endif
        exp_grant.push_back(3'b100);
        push_end(1'b0, 1);
        wait_end("cont2", 200);
        req = '0;
        tick();

        // Lock lost after the first ack: next FIRE times out.
        req_salvo = 9'd4;
        req       = 3'b001;
        exp_grant.push_back(3'b001);
        push_end(1'b1, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(grant != '0 && fired_count == 3'd1) && n < 50);
        check_eq("lock_first_ack", int'(fired_count), 1);
        target_locked = 1'b0;
        wait_end("lock_loss", 200);
        check_eq("timeout_latency", cyc - last_rise, ACK_TIMEOUT);
        req           = '0;
        target_locked = 1'b1;
        tick();

        // Launch in the same cycle the owner withdraws: counted, then abort.
        req_salvo = 9'd3;
        req       = 3'b001;
        exp_grant.push_back(3'b001);
        push_end(1'b1, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!launch_missile && n < 50);
        req = '0;
        wait_end("launch_withdraw", 50);
        tick();

        // Magazine runs out mid-salvo, then a request against an empty magazine.
        remaining_missiles = 4'd2;
        mag_track          = 1'b1;
        req_salvo          = 9'd5;
        req                = 3'b001;
        exp_grant.push_back(3'b001);
        push_end(1'b1, 2);
        wait_end("magazine", 200);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("empty_mag_state", int'(seq_state), 0);
            check_eq("empty_mag_grant", int'(grant), 0);
        end
        req                = '0;
        mag_track          = 1'b0;
        remaining_missiles = 4'd6;
        tick();

        // Owner withdraws during GAP.
        req_salvo = 9'd3;
        req       = 3'b001;
        exp_grant.push_back(3'b001);
        push_end(1'b1, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (seq_state != 3'd2 && n < 50);
        req = '0;
        tick();
        check_eq("gap_withdraw_abort", int'(abort), 1);
        tick();

        // Reset during the second FIRE burst.
        req_salvo = 9'd3;
        req       = 3'b001;
        exp_grant.push_back(3'b001);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(grant != '0 && fired_count == 3'd1 && fire_command) && n < 50);
        check_eq("pre_rst_fire", int'(fire_command), 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_fire", int'(fire_command), 0);
        check_eq("mid_rst_state", int'(seq_state), 0);
        check_eq("mid_rst_fired", int'(fired_count), 0);
        check_eq("mid_rst_grant", int'(grant), 0);
        rst = 1'b0;
        req = '0;
        tick();
        tick();

        check_eq("sb_drain", exp_end.size() + exp_grant.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
